downstream_processor: RTL
=========================

# downstream_processor

Downstream half of the per-client risk path. Accepts execution reports from the exchange side over a valid/ready handshake and maintains a 32-entry per-client cancelled-quantity table with a three-state read-modify-write FSM. Serves the upstream order processor's `cancelled_orders` lookup through a registered query port with write bypass. Emits a one-cycle update strobe per committed record.

## Interface
Parameters:
- `CLIENTS`, 32: number of table entries; client index width is 5 bits.
- `AMT_W`, 16: width of quantities and table entries.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `HRESET` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: exchange report present.
- `in_ready` out 1: block can accept a report.
- `in_client_id` in 5: client index of the report.
- `in_type` in 2: 00 CANCEL_ACK (add), 01 CLEAR (set to 0), 10 CORRECT (subtract), 11 illegal.
- `in_amount` in 16: report quantity.
- `q_client_id` in 5: upstream lookup index.
- `q_cancelled` out 16: cancelled quantity for the `q_client_id` sampled on the previous edge.
- `upd_valid` out 1: one-cycle pulse, table entry committed.
- `upd_client_id` out 5: client index of the committed entry.
- `upd_value` out 16: new committed value.
- `err_illegal` out 1: one-cycle pulse, type 11 report dropped.
- `err_ovf` out 1: one-cycle pulse, add overflowed or subtract underflowed.

## Operation
- FSM states: IDLE, LOOKUP, UPDATE.
  - IDLE: `in_ready`=1. On `in_valid`, the block captures client, type, and amount.
    - Type 11: `err_illegal` pulses next cycle and the FSM stays in IDLE.
    - Any other type: the FSM goes to LOOKUP.
  - LOOKUP: reads `table[client]` into an operand register, then goes to UPDATE.
  - UPDATE: computes the result, writes the table, and asserts `upd_*` and `err_ovf` on the next edge, then returns to IDLE.
- Arithmetic uses a 17-bit intermediate.
  - CANCEL_ACK: old + amount.
  - CORRECT: old − amount.
  - CLEAR: 0, regardless of amount.
- Overflow on add (carry out) and underflow on subtract (borrow) set `err_ovf`. The committed value depends on `DOWNSTREAM_SAT_EN` (see Configuration).
- Query port: `q_cancelled` <= `table[q_client_id]` every cycle. If the UPDATE write hits the same index on the same edge, `q_cancelled` takes the new value (write-first bypass).
- Table entries are not reset-initialised by the array itself; reset drives an init sweep instead (below).

## Timing
- Reset values: `in_ready`=0, `q_cancelled`=0, `upd_valid`=0, `upd_client_id`=0, `upd_value`=0, `err_illegal`=0, `err_ovf`=0. FSM goes to INIT.
- INIT: after `HRESET` deasserts, the block writes 0 to entries 0..31, one per cycle (32 cycles), then enters IDLE with `in_ready`=1.
  - During INIT, `q_cancelled` returns 0.
- Acceptance: a report transfers on a rising edge with `in_valid` && `in_ready`. `in_valid` may be held; the report is not consumed twice.
- Latency: acceptance edge N → `upd_valid` high in cycle N+3. `in_ready` falls in cycle N+1 and rises again in cycle N+3.
  - Throughput: one report per 3 cycles.
- Illegal report: accepted at N, `err_illegal` high in cycle N+1, `in_ready` stays 1.
- Query latency is 1 cycle. The bypass makes `q_cancelled` equal `upd_value` in the same cycle that `upd_valid` is high.
- Back-to-back reports to the same client are correct with no extra stall, because LOOKUP of report k+1 follows the table write of report k.
- `HRESET` asserted mid-operation aborts the in-flight report: no `upd_valid`, and the table is re-swept to 0.

## Configuration
- `DOWNSTREAM_SAT_EN` defined:
  - Overflow clamps the result to 16'hFFFF.
  - Underflow clamps the result to 0.
  - `err_ovf` still pulses.
- Undefined:
  - The result wraps modulo 2^16 (low 16 bits of the intermediate).
  - `err_ovf` still pulses.

## Test plan
- Reset, wait 32 cycles → `in_ready` rises on cycle 33 after release; `q_client_id`=7 gives `q_cancelled`=0.
- CANCEL_ACK client 3 amount 100, then CANCEL_ACK client 3 amount 50 back-to-back → `upd_value` 100, then 150, each 3 cycles after its acceptance; query for client 3 returns 150.
- Client 5 at 16'hFFF0, CANCEL_ACK amount 32 → `err_ovf`=1 and `upd_value`=16'hFFFF with `DOWNSTREAM_SAT_EN`, 16'h0010 without.
- Client 9 at 10, CORRECT 20 → `err_ovf`=1 and `upd_value`=0 saturating, 16'hFFF6 wrapping. Then CLEAR → `upd_value`=0, `err_ovf`=0.
- Type 11 with `in_valid` held 1 cycle → `err_illegal` pulses once, no `upd_valid`, table unchanged.
- `HRESET` pulsed in the UPDATE state of a CANCEL_ACK client 2 amount 40 → no `upd_valid`; after the sweep, query for client 2 returns 0.

Source files
------------

// File: rtl/downstream_processor.sv
// Per-client cancelled-quantity table: INIT sweep, IDLE/LOOKUP/UPDATE read-modify-write, bypassed query port.
// Optional macro DOWNSTREAM_SAT_EN: clamp on overflow/underflow instead of wrapping.
module downstream_processor #(
  parameter int CLIENTS = 32,
  parameter int AMT_W   = 16
) (
  input  logic                       clk,
  input  logic                       HRESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(CLIENTS)-1:0] in_client_id,
  input  logic [1:0]                 in_type,
  input  logic [AMT_W-1:0]           in_amount,
  input  logic [$clog2(CLIENTS)-1:0] q_client_id,
  output logic [AMT_W-1:0]           q_cancelled,
  output logic                       upd_valid,
  output logic [$clog2(CLIENTS)-1:0] upd_client_id,
  output logic [AMT_W-1:0]           upd_value,
  output logic                       err_illegal,
  output logic                       err_ovf
);
  localparam int ID_W = $clog2(CLIENTS);
  localparam logic [1:0] T_ACK = 2'b00;
  localparam logic [1:0] T_CLR = 2'b01;
  localparam logic [1:0] T_COR = 2'b10;
  localparam logic [1:0] T_ILL = 2'b11;

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, LOOKUP = 2'd2, UPDATE = 2'd3} state_t;

  state_t           state_r;
  logic [ID_W-1:0]  init_idx_r;
  logic [ID_W-1:0]  client_r;
  logic [1:0]       type_r;
  logic [AMT_W-1:0] amount_r;
  logic [AMT_W-1:0] operand_r;
  logic [AMT_W-1:0] table_r [CLIENTS];

  logic [AMT_W:0]   sum_s;
  logic [AMT_W:0]   diff_s;
  logic [AMT_W-1:0] result_s;
  logic             ovf_s;
  logic             we_s;
  logic [ID_W-1:0]  wr_addr_s;
  logic [AMT_W-1:0] wr_data_s;

  // Result of the pending report; bit AMT_W of the 17-bit intermediate is carry/borrow
  always_comb begin
    sum_s    = {1'b0, operand_r} + {1'b0, amount_r};
    diff_s   = {1'b0, operand_r} - {1'b0, amount_r};
    result_s = {AMT_W{1'b0}};
    ovf_s    = 1'b0;
    case (type_r)
      T_ACK: begin
        ovf_s = sum_s[AMT_W];
`ifdef DOWNSTREAM_SAT_EN
        result_s = sum_s[AMT_W] ? {AMT_W{1'b1}} : sum_s[AMT_W-1:0];
`else
        result_s = sum_s[AMT_W-1:0];
`endif
      end
      T_COR: begin
        ovf_s = diff_s[AMT_W];
`ifdef DOWNSTREAM_SAT_EN
        result_s = diff_s[AMT_W] ? {AMT_W{1'b0}} : diff_s[AMT_W-1:0];
`else
        result_s = diff_s[AMT_W-1:0];
`endif
      end
      T_CLR: begin
        result_s = {AMT_W{1'b0}};
        ovf_s    = 1'b0;
      end
      default: begin
        result_s = {AMT_W{1'b0}};
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Single table write port shared by the init sweep and the UPDATE commit
  always_comb begin
    we_s      = 1'b0;
    wr_addr_s = client_r;
    wr_data_s = result_s;
    case (state_r)
      INIT: begin
        we_s      = 1'b1;
        wr_addr_s = init_idx_r;
        wr_data_s = {AMT_W{1'b0}};
      end
      UPDATE:  we_s = 1'b1;
      default: we_s = 1'b0;
    endcase
  end

  // Table storage, deliberately not reset; the INIT sweep clears it
  always_ff @(posedge clk) begin
    if (we_s) begin
      table_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      state_r       <= INIT;
      init_idx_r    <= {ID_W{1'b0}};
      client_r      <= {ID_W{1'b0}};
      type_r        <= T_ACK;
      amount_r      <= {AMT_W{1'b0}};
      operand_r     <= {AMT_W{1'b0}};
      in_ready      <= 1'b0;
      upd_valid     <= 1'b0;
      upd_client_id <= {ID_W{1'b0}};
      upd_value     <= {AMT_W{1'b0}};
      err_illegal   <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      upd_valid   <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      case (state_r)
        INIT: begin
          init_idx_r <= init_idx_r + ID_W'(1);
          if (init_idx_r == ID_W'(CLIENTS - 1)) begin
            state_r  <= IDLE;
            in_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            client_r <= in_client_id;
            type_r   <= in_type;
            amount_r <= in_amount;
            if (in_type == T_ILL) begin
              err_illegal <= 1'b1;
            end else begin
              state_r  <= LOOKUP;
              in_ready <= 1'b0;
            end
          end
        end
        LOOKUP: begin
          operand_r <= table_r[client_r];
          state_r   <= UPDATE;
        end
        UPDATE: begin
          upd_valid     <= 1'b1;
          upd_client_id <= client_r;
          upd_value     <= result_s;
          err_ovf       <= ovf_s;
          state_r       <= IDLE;
          in_ready      <= 1'b1;
        end
        default: begin
          state_r  <= INIT;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Query port: write-first bypass so a same-edge commit is visible immediately
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      q_cancelled <= {AMT_W{1'b0}};
    end else if (state_r == INIT) begin
      q_cancelled <= {AMT_W{1'b0}};
    end else if (we_s && (wr_addr_s == q_client_id)) begin
      q_cancelled <= wr_data_s;
    end else begin
      q_cancelled <= table_r[q_client_id];
    end
  end
endmodule
